seq_restoring_divider: RTL and testbench

//   Multi-cycle unsigned restoring divider: Q = N / D, R = N % D.

---
 rtl/seq_restoring_divider.sv | 110 +++++++++++
 tb/tb_seq_restoring_divider.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock using a
// single shared WIDTH+1-bit subtractor. Results are held until the next accepted start.
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state;
  logic [WIDTH:0]   p;
  logic [WIDTH-1:0] qs;
  logic [WIDTH-1:0] dreg;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   pt;
  logic [WIDTH+1:0] diff;
  logic             carry;
  logic [WIDTH:0]   p_next;
  logic [WIDTH-1:0] qs_next;

  // Trial subtraction as A + ~B + 1; the carry-out means no borrow, i.e. Pt >= D.
  always_comb begin
    pt      = {p[WIDTH-1:0], qs[WIDTH-1]};
    diff    = {1'b0, pt} + {1'b0, ~{1'b0, dreg}} + {{(WIDTH+1){1'b0}}, 1'b1};
    carry   = diff[WIDTH+1];
    p_next  = carry ? diff[WIDTH:0] : pt;
    qs_next = {qs[WIDTH-2:0], carry};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      p           <= '0;
      qs          <= '0;
      dreg        <= '0;
      count       <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            qs          <= dividend;
            dreg        <= divisor;
            p           <= '0;
            count       <= '0;
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              // Division by zero skips CALC and reports immediately.
              state       <= DONE;
              busy        <= 1'b0;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end

        CALC: begin
          p     <= p_next;
          qs    <= qs_next;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= qs_next;
            remainder <= p_next[WIDTH-1:0];
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: an arithmetic reference model
// checked every cycle, plus directed cases with hand-computed results.
module tb_seq_restoring_divider;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] dividend = '0;
  logic [WIDTH-1:0] divisor = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int vectors = 0;
  int miscompares = 0;

  seq_restoring_divider #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: results come straight from / and %, timing from a countdown.
  typedef enum {M_IDLE, M_BUSY, M_DONE} mphase_e;
  mphase_e          mPhase = M_IDLE;
  int               mRemain = 0;
  logic [WIDTH-1:0] mQ = '0, mR = '0, pendQ = '0, pendR = '0;
  logic             mDbz = 1'b0;
  bit               mValid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mPhase = M_IDLE; mQ = '0; mR = '0; mDbz = 1'b0; mValid = 1'b1;
    end else if (mPhase != M_BUSY && start) begin
      if (divisor == 0) begin
        mPhase = M_DONE; mQ = '1; mR = dividend; mDbz = 1'b1;
      end else begin
        mPhase = M_BUSY; mRemain = WIDTH; mDbz = 1'b0;
        pendQ = dividend / divisor; pendR = dividend % divisor;
      end
    end else if (mPhase == M_BUSY) begin
      mRemain--;
      if (mRemain == 0) begin
        mPhase = M_DONE; mQ = pendQ; mR = pendR;
      end
    end else if (mPhase == M_DONE) begin
      mPhase = M_IDLE;
    end
  end

  always @(negedge clk) begin
    if (mValid) begin
      checkOutput("model_busy", busy, mPhase == M_BUSY);
      checkOutput("model_done", done, mPhase == M_DONE);
      checkOutput("model_quotient", quotient, mQ);
      checkOutput("model_remainder", remainder, mR);
      if (mPhase == M_DONE) checkOutput("model_dbz", div_by_zero, mDbz);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Drive one start cycle (cycle 0); returns in cycle 1.
  task automatic applyStimulus(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d);
    dividend = n;
    divisor  = d;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Starts an operation and waits for done, checking latency and results; returns in the done cycle.
  task automatic runOp(input string name, input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d,
                       input logic [WIDTH-1:0] expQ, input logic [WIDTH-1:0] expR);
    int cycles = 0;
    int busyCnt = 0;
    applyStimulus(n, d);
    while (!done && cycles < 20) begin
      if (busy) busyCnt++;
      tick();
      cycles++;
    end
    checkOutput({name, "_latency"}, cycles, (d == 0) ? 0 : WIDTH);
    checkOutput({name, "_busy_cycles"}, busyCnt, (d == 0) ? 0 : WIDTH);
    checkOutput({name, "_done"}, done, 1);
    checkOutput({name, "_q"}, quotient, expQ);
    checkOutput({name, "_r"}, remainder, expR);
    checkOutput({name, "_dbz"}, div_by_zero, d == 0);
  endtask

  initial begin
    tick();
    tick();
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_q", quotient, 0);
    checkOutput("reset_r", remainder, 0);
    checkOutput("reset_dbz", div_by_zero, 0);
    rst = 1'b0;
    tick();

    runOp("div13_3", 4'd13, 4'd3, 4'd4, 4'd1);
    tick();
    checkOutput("done_one_cycle", done, 0);
    runOp("div15_1", 4'd15, 4'd1, 4'd15, 4'd0);
    tick();
    runOp("div7_9", 4'd7, 4'd9, 4'd0, 4'd7);
    tick();
    runOp("div0_5", 4'd0, 4'd5, 4'd0, 4'd0);
    tick();
    runOp("div9_0", 4'd9, 4'd0, 4'hF, 4'd9);
    tick();

    // Start while calculating must be ignored.
    applyStimulus(4'd13, 4'd3);
    tick();
    dividend = 4'd8; divisor = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checkOutput("ignore_not_done_c4", done, 0);
    tick();
    checkOutput("ignore_done_c5", done, 1);
    checkOutput("ignore_q", quotient, 4'd4);
    checkOutput("ignore_r", remainder, 4'd1);

    // Back-to-back start in the done cycle.
    applyStimulus(4'd14, 4'd4);
    checkOutput("b2b_done_drops", done, 0);
    checkOutput("b2b_q_held", quotient, 4'd4);
    while (!done && vectors < 1000000) begin
      tick();
      if (busy === 1'b0 && done === 1'b0) break;
    end
    checkOutput("b2b_done", done, 1);
    checkOutput("b2b_q", quotient, 4'd3);
    checkOutput("b2b_r", remainder, 4'd2);
    tick();

    // Reset in cycle 2 aborts the operation.
    applyStimulus(4'd13, 4'd3);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_q", quotient, 0);
    checkOutput("abort_r", remainder, 0);
    checkOutput("abort_dbz", div_by_zero, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("abort_no_done", done, 0);
    end

    // Random traffic, including starts during CALC and occasional resets.
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(63) == 0);
      start    = ($urandom_range(2) == 0);
      dividend = WIDTH'($urandom);
      divisor  = ($urandom_range(7) == 0) ? '0 : WIDTH'($urandom);
      tick();
    end
    rst = 1'b0;
    start = 1'b0;
    repeat (8) tick();

    // Exhaustive sweep of every operand pair.
    for (int n = 0; n < (1 << WIDTH); n++) begin
      for (int d = 0; d < (1 << WIDTH); d++) begin
        runOp("sweep", WIDTH'(n), WIDTH'(d),
              (d == 0) ? '1 : WIDTH'(n / d), (d == 0) ? WIDTH'(n) : WIDTH'(n % d));
      end
    end
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
